// File: rtl/jt900h_intctrl.sv
// Interrupt controller for the jt900h CPU: one-shot timer (source 0) plus three
// rising-edge external requests (sources 1-3), level-prioritised and held until acknowledged.
module jt900h_intctrl #(
    parameter logic [2:0] VBASE = 3'd1,
    parameter int         CNTW  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        cs,
    input  logic [1:0]  addr,
    input  logic [15:0] din,
    input  logic [1:0]  we,
    output logic [15:0] dout,
    input  logic [2:0]  ext_req,
    output logic        irq,
    output logic [2:0]  int_lvl,
    output logic [7:0]  int_addr,
    input  logic        irq_ack
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            r_state;
    logic [3:0]        r_pend;
    logic [CNTW-1:0]   r_count;
    logic [CNTW-1:0]   r_reload;
    logic [2:0]        r_tlvl;
    logic              r_run;
    logic [15:0]       r_level;
    logic [2:0]        r_ext_prev;
    logic [1:0]        r_gsrc;

    logic              w_wr, w_wr_timer, w_wr_pend, w_wr_level;
    logic              w_fire, w_ack;
    logic [3:0]        w_set, w_clr, w_pend_nxt;
    logic [2:0]        w_lvl [4];
    logic [3:0]        w_en;
    logic [2:0]        w_best_lvl;
    logic [1:0]        w_best_src;
    logic [7:0]        w_count8;

    assign w_wr       = cs & cen & we[0];
    assign w_wr_timer = w_wr && (addr == 2'd0);
    assign w_wr_pend  = w_wr && (addr == 2'd1);
    assign w_wr_level = w_wr && (addr == 2'd2);
    assign w_fire     = r_run && (r_count == '0);
    assign w_ack      = cen && irq_ack && (r_state == REQ);

    // Set terms are OR'ed after clears so a set and clear in the same cycle leaves the bit set.
    assign w_set      = {ext_req & ~r_ext_prev, w_fire};
    assign w_clr      = (w_wr_pend ? din[3:0] : 4'd0)
                      | {3'd0, w_wr_timer}
                      | (w_ack ? (4'b0001 << r_gsrc) : 4'd0);
    assign w_pend_nxt = (r_pend & ~w_clr) | w_set;

    // The timer's own level register doubles as its enable; sources 1-3 use the LEVEL nibbles.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_lvl[0] = r_tlvl;
        w_en     = {r_level[15], r_level[11], r_level[7], |r_tlvl};
        for (int i = 1; i < 4; i++) begin
            w_lvl[i] = r_level[4*i +: 3];
        end
    end

    // Strict greater-than while scanning upward keeps the lowest index on ties and rejects level 0.
    always_comb begin
        w_best_lvl = '0;
        w_best_src = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_pend[i] && w_en[i] && (w_lvl[i] > w_best_lvl)) begin
                w_best_lvl = w_lvl[i];
                w_best_src = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            r_pend     <= '0;
            r_count    <= '0;
            r_reload   <= '0;
            r_tlvl     <= '0;
            r_run      <= 1'b0;
            r_level    <= '0;
            r_ext_prev <= '0;
        end else if (cen) begin
            r_pend     <= w_pend_nxt;
            r_ext_prev <= ext_req;
            if (w_wr_timer) begin
                if (we[1]) begin
                    r_count  <= din[8 +: CNTW];
                    r_reload <= din[8 +: CNTW];
                end else begin
                    r_count  <= r_reload;
                end
                r_tlvl <= din[2:0];
                r_run  <= (din[2:0] != 3'd0);
            end else if (r_run) begin
                if (r_count == '0) r_run <= 1'b0;
                else               r_count <= r_count - CNTW'(1);
            end
            if (w_wr_level) r_level <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            irq      <= 1'b0;
            int_lvl  <= 3'd0;
            int_addr <= {VBASE, 5'd0};
            r_gsrc   <= 2'd0;
        end else if (cen) begin
            case (r_state)
                IDLE: if (w_best_lvl != 3'd0) begin
                    irq      <= 1'b1;
                    int_lvl  <= w_best_lvl;
                    int_addr <= {VBASE, w_best_lvl, 2'b00};
                    r_gsrc   <= w_best_src;
                    r_state  <= REQ;
                end
                REQ: if (irq_ack || !r_pend[r_gsrc] || !w_en[r_gsrc]) begin
                    irq     <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_count8             = '0;
        w_count8[CNTW-1:0]   = r_count;
        case (addr)
            2'd0:    dout = {w_count8, 5'd0, r_tlvl};
            2'd1:    dout = {12'd0, r_pend};
            2'd2:    dout = r_level;
            default: dout = {irq, 7'd0, 2'd0, r_gsrc, 1'b0, int_lvl};
        endcase
    end

endmodule

// File: tb/tb_jt900h_intctrl.sv
// Directed bench for jt900h_intctrl: stimulus queues expected grants, a negedge monitor
// pops one per irq rising edge and compares level, vector and (where known) timing.
module tb_jt900h_intctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic        cs = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] din = 16'd0;
    logic [1:0]  we = 2'd0;
    logic [15:0] dout;
    logic [2:0]  ext_req = 3'd0;
    logic        irq;
    logic [2:0]  int_lvl;
    logic [7:0]  int_addr;
    logic        irq_ack = 1'b0;

    typedef struct {
        int lvl;
        int vec;
        int cyc;   // expected cycle of irq rise, -1 when not checked
    } grant_t;

    grant_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_wr = 0;
    logic irq_q = 1'b0;

    jt900h_intctrl dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cs(cs), .addr(addr), .din(din),
        .we(we), .dout(dout), .ext_req(ext_req), .irq(irq), .int_lvl(int_lvl),
        .int_addr(int_addr), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every irq rise must match the oldest queued grant.
    always @(negedge clk) begin
        if (rst_n && irq && !irq_q) begin
            check("grant_queued", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                grant_t g;
                g = sb.pop_front();
                check("grant_lvl", 32'(int_lvl), 32'(g.lvl));
                check("grant_vec", 32'(int_addr), 32'(g.vec));
                if (g.cyc >= 0) check("grant_cycle", 32'(cyc), 32'(g.cyc));
            end
        end
        irq_q = irq;
    end

    task automatic push(input int lvl, input int vec, input int at);
        grant_t g;
        g.lvl = lvl; g.vec = vec; g.cyc = at;
        sb.push_back(g);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cs = 1'b1; addr = a; din = d; we = 2'b11;
        @(posedge clk); #1;
        cs = 1'b0; we = 2'b00;
        last_wr = cyc;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        check(name, 32'(dout), 32'(exp));
    endtask

    task automatic pulse(input logic [2:0] v);
        ext_req = v;
        @(posedge clk); #1;
        ext_req = 3'd0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        @(posedge clk); #1;
        irq_ack = 1'b0;
        @(negedge clk);
        check("irq_low_after_ack", 32'(irq), 0);
    endtask

    task automatic wait_irq(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (irq) break;
        end
        check(name, 32'(irq), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Reset state
        check("rst_irq", 32'(irq), 0);
        check("rst_lvl", 32'(int_lvl), 0);
        check("rst_vec", 32'(int_addr), 32'h20);
        rd_check("rst_timer", 2'd0, 16'h0000);
        rd_check("rst_status", 2'd3, 16'h0000);

        // Timer: load 5 at level 3 -> irq 7 cycles after the write edge
        wr(2'd0, 16'h0503);
        push(3, 8'h2C, last_wr + 7);
        wait_irq("timer_irq", 20);
        rd_check("timer_status", 2'd3, 16'h8003);
        rd_check("timer_reg", 2'd0, 16'h0003);
        ack();
        rd_check("timer_pend", 2'd1, 16'h0000);

        // Timer restart: a second write while running reloads the count
        wr(2'd0, 16'h0A01);
        idle(2);
        wr(2'd0, 16'h0201);
        push(1, 8'h24, last_wr + 4);
        wait_irq("restart_irq", 20);
        ack();
        wr(2'd0, 16'h0000);

        // Priority: src3 lvl4, src1 lvl3, src2 lvl2
        wr(2'd2, 16'hCAB9);
        push(4, 8'h30, -1);
        push(3, 8'h2C, -1);
        push(2, 8'h28, -1);
        pulse(3'b111);
        for (int k = 0; k < 3; k++) begin
            wait_irq("prio_irq", 10);
            ack();
        end
        rd_check("prio_pend", 2'd1, 16'h0000);

        // Tie at level 5: src1 before src2; later level-7 src3 waits for ack
        wr(2'd2, 16'hFDD0);
        push(5, 8'h34, -1);
        pulse(3'b011);
        wait_irq("tie_irq", 10);
        rd_check("tie_status", 2'd3, 16'h8015);
        push(7, 8'h3C, -1);
        push(5, 8'h34, -1);
        pulse(3'b100);
        idle(3);
        rd_check("no_preempt", 2'd3, 16'h8015);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_irq("tie_next_irq", 10);
            ack();
        end

        // Withdraw: software clears the granted pending bit
        push(5, 8'h34, -1);
        pulse(3'b001);
        wait_irq("wd_irq", 10);
        wr(2'd1, 16'h0002);
        idle(1);
        @(negedge clk);
        check("wd_irq_low", 32'(irq), 0);
        rd_check("wd_pend", 2'd1, 16'h0000);

        // Held level: exactly one grant over 50 cycles
        push(5, 8'h34, -1);
        ext_req = 3'b001;
        wait_irq("held_irq", 10);
        ack();
        idle(45);
        @(negedge clk);
        check("held_no_regrant", 32'(irq), 0);
        ext_req = 3'b000;
        idle(1);
        rd_check("held_pend", 2'd1, 16'h0000);

        // Disabled source stays silent until enabled
        wr(2'd2, 16'h0050);
        pulse(3'b001);
        idle(10);
        check("dis_irq", 32'(irq), 0);
        rd_check("dis_pend", 2'd1, 16'h0002);
        push(5, 8'h34, -1);
        wr(2'd2, 16'h00D0);
        wait_irq("en_irq", 10);
        ack();
        rd_check("en_pend", 2'd1, 16'h0000);

        // Reset in the middle of a request, with cen toggling
        push(5, 8'h34, -1);
        pulse(3'b001);
        wait_irq("rst_req_irq", 10);
        #2 rst_n = 1'b0;
        #1 check("async_rst_irq", 32'(irq), 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 cen = ~cen;
        end
        cen = 1'b1;
        rst_n = 1'b1;
        idle(1);
        rd_check("post_timer", 2'd0, 16'h0000);
        rd_check("post_pend", 2'd1, 16'h0000);
        rd_check("post_level", 2'd2, 16'h0000);
        rd_check("post_status", 2'd3, 16'h0000);
        check("post_vec", 32'(int_addr), 32'h20);
        irq_ack = 1'b1;
        idle(1);
        irq_ack = 1'b0;
        idle(2);
        rd_check("ack_idle_status", 2'd3, 16'h0000);
        check("ack_idle_irq", 32'(irq), 0);

        check("grants_left", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
